// File: rtl/instr_sequencer.sv
// instr_sequencer: 16-bit instruction FIFO feeding an IDLE/EXEC/CAPTURE
// issue FSM that drives reg_file_alu and captures its result.
module instr_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic [7:0]  ALUResult,
  output logic [3:0]  RA1,
  output logic [3:0]  RA2,
  output logic [3:0]  WA,
  output logic [7:0]  external_data_in,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        result_valid,
  output logic [7:0]  result,
  output logic        busy,
  output logic [7:0]  retired
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_ALU  = 2'b01,
    OP_ALUI = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa;
    logic [7:0] imm;
    logic       regwrite;
    logic       alusrc;
    logic [1:0] aluctrl;
  } ctl_t;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  op_t           op_q, op_d;
  ctl_t          ctl_q, ctl_d;
  logic [7:0]    result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic [7:0]    retired_q, retired_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  op_t           head_op;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign instr_ready = reset && !full;
  assign push    = instr_valid && instr_ready;
  assign pop     = (state_q == IDLE) && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign head_op = op_t'(head[15:14]);

  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    op_d           = op_q;
    ctl_d          = '0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    retired_d      = retired_q;

    if (push) begin
      mem_d[wr_ptr_q] = instr;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Controls are decoded from the head as it is popped so they
    // are already registered during the EXEC cycle.
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = EXEC;
          op_d    = head_op;
          unique case (1'b1)
            head_op == OP_LDI: begin
              ctl_d.wa       = head[13:10];
              ctl_d.imm      = head[7:0];
              ctl_d.regwrite = 1'b1;
              ctl_d.alusrc   = 1'b1;
            end
            head_op == OP_ALU: begin
              ctl_d.aluctrl = head[13:12];
              ctl_d.ra1     = head[11:8];
              ctl_d.ra2     = head[7:4];
            end
            head_op == OP_ALUI: begin
              ctl_d.aluctrl = head[13:12];
              ctl_d.ra1     = head[11:8];
              ctl_d.imm     = head[7:0];
              ctl_d.alusrc  = 1'b1;
            end
            default: ctl_d = '0;
          endcase
        end
      end
      EXEC: begin
        if (op_q == OP_ALU || op_q == OP_ALUI) begin
          state_d = CAPTURE;
          ctl_d   = ctl_q;
          ctl_d.regwrite = 1'b0;
        end else begin
          state_d   = IDLE;
          retired_d = retired_q + 8'd1;
        end
      end
      CAPTURE: begin
        state_d        = IDLE;
        result_d       = ALUResult;
        result_valid_d = 1'b1;
        retired_d      = retired_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= IDLE;
      op_q           <= OP_NOP;
      ctl_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      retired_q      <= '0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      op_q           <= op_d;
      ctl_q          <= ctl_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      retired_q      <= retired_d;
    end
  end

  assign RA1              = ctl_q.ra1;
  assign RA2              = ctl_q.ra2;
  assign WA               = ctl_q.wa;
  assign external_data_in = ctl_q.imm;
  assign RegWrite         = ctl_q.regwrite;
  assign ALUSrc           = ctl_q.alusrc;
  assign ALUControl       = ctl_q.aluctrl;
  assign result_valid     = result_valid_q;
  assign result           = result_q;
  assign retired          = retired_q;
  assign busy             = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized bench with a behavioural reg_file_alu
// and a sequential instruction-level reference model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  ALUResult;
  logic [3:0]  RA1;
  logic [3:0]  RA2;
  logic [3:0]  WA;
  logic [7:0]  external_data_in;
  logic        RegWrite;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        result_valid;
  logic [7:0]  result;
  logic        busy;
  logic [7:0]  retired;

  int checks = 0;
  int passes = 0;
  int exp_retired = 0;

  logic [7:0] rf [16] = '{default: 8'h00};
  logic [7:0] ref_rf [16] = '{default: 8'h00};

  instr_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .ALUResult(ALUResult),
    .RA1(RA1),
    .RA2(RA2),
    .WA(WA),
    .external_data_in(external_data_in),
    .RegWrite(RegWrite),
    .ALUSrc(ALUSrc),
    .ALUControl(ALUControl),
    .result_valid(result_valid),
    .result(result),
    .busy(busy),
    .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_op(input logic [1:0] c,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    case (c)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  // Downstream reg_file_alu stand-in.
  always @(posedge clk) begin
    if (RegWrite === 1'b1) rf[WA] <= external_data_in;
  end
  assign ALUResult = alu_op(ALUControl, rf[RA1],
                            ALUSrc ? external_data_in : rf[RA2]);

  // Instruction-level model: executes one word in program order.
  function automatic logic [7:0] model_exec(input logic [15:0] w,
                                            output bit has_res);
    logic [7:0] a;
    a = ref_rf[w[11:8]];
    has_res = 1'b0;
    model_exec = 8'h00;
    case (w[15:14])
      2'b00: ref_rf[w[13:10]] = w[7:0];
      2'b01: begin
        has_res = 1'b1;
        model_exec = alu_op(w[13:12], a, ref_rf[w[7:4]]);
      end
      2'b10: begin
        has_res = 1'b1;
        model_exec = alu_op(w[13:12], a, w[7:0]);
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    int n = 0;
    instr_valid = 1'b1;
    instr = w;
    while (instr_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (n >= 50)
      $display("FAIL push_timeout word=%h ready=%b required=1", w, instr_ready);
    else passes++;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0)
      $display("FAIL %s_idle_timeout busy=%b required=0", tag, busy);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr_valid = 1'b1;
    instr = 16'h1405;
    repeat (3) tick();
    checks++;
    if ({RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl} !== 24'd0)
      $display("FAIL reset_ctl got=%h required=0",
               {RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl});
    else passes++;
    checks++;
    if ({result_valid, result, retired, busy} !== 18'd0)
      $display("FAIL reset_status got=%h required=0",
               {result_valid, result, retired, busy});
    else passes++;
    checks++;
    if (instr_ready !== 1'b0)
      $display("FAIL reset_ready got=%b required=0", instr_ready);
    else passes++;
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (instr_ready !== 1'b1)
      $display("FAIL release_ready got=%b required=1", instr_ready);
    else passes++;
    checks++;
    if (busy !== 1'b0)
      $display("FAIL release_busy got=%b required=0", busy);
    else passes++;
  endtask

  task automatic test_ldi();
    logic [15:0] w = 16'h1405;
    bit hr;
    void'(model_exec(w, hr));
    exp_retired++;
    push(w);
    checks++;
    if (RegWrite !== 1'b0)
      $display("FAIL ldi_pop_regwrite got=%b required=0", RegWrite);
    else passes++;
    tick();
    checks++;
    if ({WA, external_data_in, RegWrite, ALUSrc} !== {4'd5, 8'd5, 1'b1, 1'b1})
      $display("FAIL ldi_exec wa=%0d imm=%0d rw=%b src=%b required 5/5/1/1",
               WA, external_data_in, RegWrite, ALUSrc);
    else passes++;
    checks++;
    if ({RA1, RA2, ALUControl} !== 10'd0)
      $display("FAIL ldi_exec_other got=%h required=0", {RA1, RA2, ALUControl});
    else passes++;
    tick();
    checks++;
    if ({RegWrite, ALUSrc, WA, external_data_in} !== 14'd0)
      $display("FAIL ldi_after got=%h required=0",
               {RegWrite, ALUSrc, WA, external_data_in});
    else passes++;
    checks++;
    if (retired !== 8'(exp_retired))
      $display("FAIL ldi_retired got=%0d required=%0d", retired, exp_retired);
    else passes++;
  endtask

  task automatic test_alu();
    logic [15:0] w1 = 16'h1004;
    logic [15:0] w2 = 16'h6540;
    logic [7:0] exp;
    bit hr;
    void'(model_exec(w1, hr));
    exp_retired++;
    push(w1);
    wait_idle("alu_ldi");
    exp = model_exec(w2, hr);
    exp_retired++;
    push(w2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        checks++;
        if ({RA1, RA2, ALUControl, ALUSrc, RegWrite, WA, external_data_in}
            !== {4'd5, 4'd4, 2'b10, 1'b0, 1'b0, 4'd0, 8'd0})
          $display("FAIL alu_ctl_c%0d ra1=%0d ra2=%0d ctl=%0d src=%b rw=%b required 5/4/2/0/0",
                   c, RA1, RA2, ALUControl, ALUSrc, RegWrite);
        else passes++;
      end
      checks++;
      if (result_valid !== (c == 3))
        $display("FAIL alu_rv_c%0d got=%b required=%b", c, result_valid, c == 3);
      else passes++;
      if (c >= 3) begin
        checks++;
        if (result !== exp)
          $display("FAIL alu_result_c%0d got=%0d required=%0d", c, result, exp);
        else passes++;
      end
    end
    checks++;
    if (retired !== 8'(exp_retired))
      $display("FAIL alu_retired got=%0d required=%0d", retired, exp_retired);
    else passes++;
  endtask

  task automatic test_alui();
    logic [15:0] w = 16'hB501;
    logic [7:0] exp;
    bit hr;
    wait_idle("alui_pre");
    exp = model_exec(w, hr);
    exp_retired++;
    push(w);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c <= 2) begin
        checks++;
        if ({RA1, ALUControl, ALUSrc, external_data_in, RegWrite}
            !== {4'd5, 2'b11, 1'b1, 8'd1, 1'b0})
          $display("FAIL alui_ctl_c%0d ra1=%0d ctl=%0d src=%b imm=%0d rw=%b required 5/3/1/1/0",
                   c, RA1, ALUControl, ALUSrc, external_data_in, RegWrite);
        else passes++;
      end
    end
    checks++;
    if (result_valid !== 1'b1 || result !== exp)
      $display("FAIL alui_result rv=%b res=%0d required 1/%0d", result_valid, result, exp);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[$];
    logic [15:0] exp_q[$];
    logic [15:0] w;
    int n = 12;
    int idx = 0;
    int pulses = 0;
    int occ;
    int full_seen = 0;
    bit hr;
    logic acc;
    wait_idle("b2b_pre");
    for (int i = 0; i < n; i++) begin
      w = {2'b00, 4'($urandom_range(0, 15)), 2'b00, 8'($urandom)};
      words.push_back(w);
      void'(model_exec(w, hr));
    end
    exp_retired += n;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (idx < n) begin
        instr_valid = 1'b1;
        instr = words[idx];
      end else instr_valid = 1'b0;
      acc = instr_valid && (instr_ready === 1'b1);
      tick();
      if (acc) begin
        exp_q.push_back(words[idx]);
        idx++;
      end
      if (RegWrite === 1'b1) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL b2b_extra_write wa=%0d imm=%0d required none", WA, external_data_in);
        else begin
          w = exp_q.pop_front();
          if ({WA, external_data_in} !== {w[13:10], w[7:0]})
            $display("FAIL b2b_write got=%h required=%h",
                     {WA, external_data_in}, {w[13:10], w[7:0]});
          else passes++;
        end
      end
      occ = idx - pulses;
      checks++;
      if (instr_ready !== (occ != 4))
        $display("FAIL b2b_ready cyc=%0d got=%b required=%b occ=%0d",
                 cyc, instr_ready, occ != 4, occ);
      else passes++;
      if (instr_ready === 1'b0) full_seen++;
      if (idx == n && busy === 1'b0) break;
    end
    instr_valid = 1'b0;
    checks++;
    if (full_seen == 0)
      $display("FAIL b2b_full_seen got=0 required>0");
    else passes++;
    checks++;
    if (pulses != n || exp_q.size() != 0)
      $display("FAIL b2b_count writes=%0d left=%0d required %0d/0", pulses, exp_q.size(), n);
    else passes++;
    checks++;
    if (retired !== 8'(exp_retired) || busy !== 1'b0)
      $display("FAIL b2b_retired got=%0d busy=%b required=%0d/0", retired, busy, exp_retired);
    else passes++;
  endtask

  task automatic test_random_mix();
    logic [15:0] words[$];
    logic [7:0] exp_res[$];
    logic [15:0] w;
    logic [7:0] r;
    int n = 24;
    int n_ldi = 0;
    int n_res;
    int idx = 0;
    int got_res = 0;
    int rw = 0;
    int bad_rf = 0;
    bit hr;
    logic acc;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      words.push_back(w);
      r = model_exec(w, hr);
      if (hr) exp_res.push_back(r);
      if (w[15:14] == 2'b00) n_ldi++;
    end
    n_res = exp_res.size();
    exp_retired += n;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (idx < n) begin
        instr_valid = 1'b1;
        instr = words[idx];
      end else instr_valid = 1'b0;
      acc = instr_valid && (instr_ready === 1'b1);
      tick();
      if (acc) idx++;
      if (RegWrite === 1'b1) rw++;
      if (result_valid === 1'b1) begin
        got_res++;
        checks++;
        if (exp_res.size() == 0)
          $display("FAIL mix_extra_result got=%0d required none", result);
        else begin
          r = exp_res.pop_front();
          if (result !== r)
            $display("FAIL mix_result #%0d got=%0d required=%0d", got_res, result, r);
          else passes++;
        end
      end
      if (idx == n && busy === 1'b0) break;
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++)
      if (rf[i] !== ref_rf[i]) bad_rf++;
    checks++;
    if (got_res != n_res || rw != n_ldi)
      $display("FAIL mix_counts results=%0d writes=%0d required %0d/%0d",
               got_res, rw, n_res, n_ldi);
    else passes++;
    checks++;
    if (bad_rf != 0)
      $display("FAIL mix_regfile mismatched=%0d required=0", bad_rf);
    else passes++;
    checks++;
    if (retired !== 8'(exp_retired) || busy !== 1'b0)
      $display("FAIL mix_retired got=%0d busy=%b required=%0d/0", retired, busy, exp_retired);
    else passes++;
  endtask

  task automatic test_capture_reset();
    logic [15:0] wa;
    logic [15:0] q1;
    logic [15:0] q2;
    int rw = 0;
    int rv = 0;
    int bz = 0;
    wait_idle("cap_pre");
    wa = {2'b01, 2'($urandom), 4'($urandom), 4'($urandom), 4'h0};
    q1 = {2'b00, 4'($urandom), 2'b00, 8'($urandom)};
    q2 = {2'b00, 4'($urandom), 2'b00, 8'($urandom)};
    push(wa);
    push(q1);
    push(q2);
    checks++;
    if ({RA1, ALUControl, busy, result_valid} !== {wa[11:8], wa[13:12], 1'b1, 1'b0})
      $display("FAIL cap_precond got=%h required=%h",
               {RA1, ALUControl, busy, result_valid}, {wa[11:8], wa[13:12], 1'b1, 1'b0});
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if ({RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl} !== 24'd0)
      $display("FAIL cap_reset_ctl got=%h required=0",
               {RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl});
    else passes++;
    checks++;
    if ({result_valid, result, retired, busy, instr_ready} !== 19'd0)
      $display("FAIL cap_reset_status got=%h required=0",
               {result_valid, result, retired, busy, instr_ready});
    else passes++;
    reset = 1'b1;
    exp_retired = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (RegWrite !== 1'b0) rw++;
      if (result_valid !== 1'b0) rv++;
      if (busy !== 1'b0) bz++;
    end
    checks++;
    if (rw != 0 || rv != 0 || bz != 0)
      $display("FAIL cap_after_release rw=%0d rv=%0d busy=%0d required 0/0/0", rw, rv, bz);
    else passes++;
    checks++;
    if (retired !== 8'(exp_retired))
      $display("FAIL cap_retired got=%0d required=%0d", retired, exp_retired);
    else passes++;
  endtask

  task automatic test_nop_wrap();
    int n = 256;
    int idx = 0;
    int seen_max = 0;
    int stray = 0;
    logic acc;
    exp_retired = (exp_retired + n) % 256;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (idx < n) begin
        instr_valid = 1'b1;
        instr = {2'b11, 14'($urandom)};
      end else instr_valid = 1'b0;
      acc = instr_valid && (instr_ready === 1'b1);
      tick();
      if (acc) idx++;
      if (retired === 8'd255) seen_max++;
      if (RegWrite !== 1'b0 || result_valid !== 1'b0) stray++;
      if (idx == n && busy === 1'b0) break;
    end
    instr_valid = 1'b0;
    checks++;
    if (seen_max == 0)
      $display("FAIL nop_reached_255 got=0 required>0");
    else passes++;
    checks++;
    if (stray != 0)
      $display("FAIL nop_side_effects got=%0d required=0", stray);
    else passes++;
    checks++;
    if (retired !== 8'(exp_retired) || busy !== 1'b0)
      $display("FAIL nop_wrap retired=%0d busy=%b required=%0d/0", retired, busy, exp_retired);
    else passes++;
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    test_reset();
    test_ldi();
    test_alu();
    test_alui();
    test_back_to_back();
    test_random_mix();
    test_capture_reset();
    test_nop_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
